// File: rtl/cim_qkv_scheduler.sv
// Sequencer for the shared CIM q/k/v projection array: arbitrates weight-memory
// column accesses against token computes and runs the Q, K, V passes per token.
module cim_qkv_scheduler #(
  parameter int IN_W  = 2048,
  parameter int OUT_W = 1024,
  parameter int COL_W = 7,
  parameter int TMO   = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic             mem_rd,
  input  logic [2:0]       mem_sel,
  input  logic [COL_W-1:0] mem_col,
  input  logic [IN_W-1:0]  mem_wdata,
  output logic             mem_rvalid,
  output logic [IN_W-1:0]  mem_rdata,
  output logic             mem_wdone,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic [IN_W-1:0]  tok_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_q,
  output logic [OUT_W-1:0] out_k,
  output logic [OUT_W-1:0] out_v,
  output logic             dp_cs,
  output logic             dp_web,
  output logic             dp_cimeb,
  output logic [2:0]       dp_weight_sel,
  output logic [COL_W-1:0] dp_col_sel,
  output logic [IN_W-1:0]  dp_data_in,
  input  logic [OUT_W-1:0] dp_data_out,
  input  logic [IN_W-1:0]  dp_mem_data_out,
  input  logic             dp_done,
  output logic             busy,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE, S_MEM_ISSUE, S_MEM_WAIT, S_CIM_ISSUE, S_CIM_WAIT, S_OUT_HOLD
  } state_t;

  localparam logic [9:0] TMO_LAST = 10'(TMO - 1);

  state_t             state, state_nxt;
  logic               prio;        // 0: memory port wins a tie, 1: token port
  logic               req_rd;
  logic [2:0]         req_sel;
  logic [COL_W-1:0]   req_col;
  logic [IN_W-1:0]    req_data;    // write data or token, whichever was granted
  logic [1:0]         pass;
  logic               gap;
  logic [9:0]         tmo_cnt;
  logic               tok_ok, grant_mem, grant_tok, tmo_hit;

  assign tok_ok    = tok_valid && !out_valid;
  assign grant_mem = !rst && mem_valid && (!tok_ok || !prio);
  assign grant_tok = !rst && tok_ok && (!mem_valid || prio);
  assign tmo_hit   = (tmo_cnt == TMO_LAST);
  assign busy      = (state != S_IDLE);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    state_nxt     = state;
    mem_ready     = 1'b0;
    tok_ready     = 1'b0;
    dp_cs         = 1'b0;
    dp_web        = 1'b1;
    dp_cimeb      = 1'b1;
    dp_weight_sel = '0;
    dp_col_sel    = '0;
    dp_data_in    = '0;
    case (state)
      S_IDLE: begin
        if (grant_mem) begin
          mem_ready = 1'b1;
          state_nxt = S_MEM_ISSUE;
        end else if (grant_tok) begin
          tok_ready = 1'b1;
          state_nxt = S_CIM_ISSUE;
        end
      end
      S_MEM_ISSUE, S_MEM_WAIT: begin
        dp_cs         = 1'b1;
        dp_web        = req_rd;
        dp_weight_sel = req_sel;
        dp_col_sel    = req_col;
        dp_data_in    = req_data;
        if (state == S_MEM_ISSUE)   state_nxt = S_MEM_WAIT;
        else if (dp_done || tmo_hit) state_nxt = S_IDLE;
      end
      S_CIM_ISSUE, S_CIM_WAIT: begin
        // A gap cycle holds chip select low between consecutive passes.
        dp_cs         = !(state == S_CIM_ISSUE && gap);
        dp_cimeb      = 1'b0;
        dp_weight_sel = {1'b0, pass};
        dp_data_in    = req_data;
        if (state == S_CIM_ISSUE) begin
          if (!gap) state_nxt = S_CIM_WAIT;
        end else if (dp_done) begin
          state_nxt = (pass == 2'd2) ? S_OUT_HOLD : S_CIM_ISSUE;
        end else if (tmo_hit) begin
          state_nxt = S_IDLE;
        end
      end
      S_OUT_HOLD: if (out_ready) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio       <= 1'b0;
      req_rd     <= 1'b0;
      req_sel    <= '0;
      req_col    <= '0;
      req_data   <= '0;
      pass       <= '0;
      gap        <= 1'b0;
      tmo_cnt    <= '0;
      mem_rvalid <= 1'b0;
      mem_wdone  <= 1'b0;
      mem_rdata  <= '0;
      out_valid  <= 1'b0;
      out_q      <= '0;
      out_k      <= '0;
      out_v      <= '0;
      err        <= 1'b0;
    end else begin
      mem_rvalid <= 1'b0;
      mem_wdone  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_mem) begin
            req_rd   <= mem_rd;
            req_sel  <= mem_sel;
            req_col  <= mem_col;
            req_data <= mem_wdata;
            prio     <= 1'b1;
          end else if (grant_tok) begin
            req_data <= tok_data;
            pass     <= '0;
            gap      <= 1'b0;
            prio     <= 1'b0;
          end
        end
        S_MEM_ISSUE: tmo_cnt <= '0;
        S_MEM_WAIT: begin
          if (dp_done) begin
            if (req_rd) begin
              mem_rdata  <= dp_mem_data_out;
              mem_rvalid <= 1'b1;
            end else begin
              mem_wdone  <= 1'b1;
            end
          end else if (tmo_hit) begin
            err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 10'd1;
          end
        end
        S_CIM_ISSUE: begin
          gap     <= 1'b0;
          tmo_cnt <= '0;
        end
        S_CIM_WAIT: begin
          if (dp_done) begin
            case (pass)
              2'd0:    out_q <= dp_data_out;
              2'd1:    out_k <= dp_data_out;
              default: out_v <= dp_data_out;
            endcase
            if (pass == 2'd2) begin
              out_valid <= 1'b1;
            end else begin
              pass <= pass + 2'd1;
              gap  <= 1'b1;
            end
          end else if (tmo_hit) begin
            err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 10'd1;
          end
        end
        S_OUT_HOLD: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cim_qkv_scheduler.sv
// Scoreboard bench for cim_qkv_scheduler with a behavioural CIM datapath model.
module tb_cim_qkv_scheduler;

  localparam int IN_W  = 2048;
  localparam int OUT_W = 1024;
  localparam int COL_W = 7;
  localparam int TMO   = 1023;
  localparam logic [1:0] K_WR = 2'd0, K_RD = 2'd1, K_TOK = 2'd2;

  logic clk = 1'b0, rst = 1'b1;
  logic mem_valid = 0, mem_rd = 0, tok_valid = 0, out_ready = 1;
  logic [2:0] mem_sel = 0;
  logic [COL_W-1:0] mem_col = 0;
  logic [IN_W-1:0] mem_wdata = 0, tok_data = 0;
  logic mem_ready, mem_rvalid, mem_wdone, tok_ready, out_valid, busy, err;
  logic [IN_W-1:0] mem_rdata, dp_data_in, dp_mem_data_out = 0;
  logic [OUT_W-1:0] out_q, out_k, out_v, dp_data_out = 0;
  logic dp_cs, dp_web, dp_cimeb, dp_done = 0;
  logic [2:0] dp_weight_sel;
  logic [COL_W-1:0] dp_col_sel;

  cim_qkv_scheduler #(.IN_W(IN_W), .OUT_W(OUT_W), .COL_W(COL_W), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_sel(mem_sel),
    .mem_col(mem_col), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_wdone(mem_wdone),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_data(tok_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_k(out_k), .out_v(out_v),
    .dp_cs(dp_cs), .dp_web(dp_web), .dp_cimeb(dp_cimeb), .dp_weight_sel(dp_weight_sel),
    .dp_col_sel(dp_col_sel), .dp_data_in(dp_data_in), .dp_data_out(dp_data_out),
    .dp_mem_data_out(dp_mem_data_out), .dp_done(dp_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [IN_W-1:0] obs, input logic [IN_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h..%h want %h..%h", tag, obs[IN_W-1 -: 32], obs[31:0],
               exp[IN_W-1 -: 32], exp[31:0]);
    end
  endtask

  function automatic logic [OUT_W-1:0] pat(input logic [2:0] s);
    logic [7:0] b;
    case (s)
      3'd0:    b = 8'h11;
      3'd1:    b = 8'h22;
      default: b = 8'h33;
    endcase
    return {(OUT_W/8){b}};
  endfunction

  function automatic logic [IN_W-1:0] rnd_vec();
    logic [IN_W-1:0] v;
    for (int i = 0; i < IN_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Datapath model: done arrives dp_lat cycles after chip select rises.
  bit dp_en = 1, dp_act = 0;
  int dp_cnt = 0, dp_lat = 9;
  logic [2:0] l_sel;
  logic [COL_W-1:0] l_col;
  logic l_web;
  logic [IN_W-1:0] l_din;
  logic [IN_W-1:0] dp_mem [0:2][0:(1<<COL_W)-1];
  logic [2:0] sel_log[$];

  always @(negedge clk) begin
    dp_done = 1'b0;
    if (!dp_cs) begin
      dp_act = 0;
    end else if (!dp_act) begin
      dp_act = 1; dp_cnt = dp_lat;
      l_sel = dp_weight_sel; l_col = dp_col_sel; l_web = dp_web; l_din = dp_data_in;
      if (!dp_cimeb) begin
        sel_log.push_back(dp_weight_sel);
        check("cim_web", dp_web, 1);
        check("cim_col", dp_col_sel, 0);
      end
    end else if (dp_en && dp_cnt > 0) begin
      dp_cnt--;
      if (dp_cnt == 0) begin
        dp_done = 1'b1;
        dp_data_out = pat(l_sel) ^ l_din[OUT_W-1:0];
        if (dp_cimeb && !l_web) dp_mem[l_sel][l_col] = l_din;
        else if (dp_cimeb) dp_mem_data_out = dp_mem[l_sel][l_col];
      end
    end
  end

  // Scoreboard: expectations are pushed on accept and popped on DUT output.
  typedef struct {
    logic [1:0] kind;
    logic [IN_W-1:0] rdata;
    logic [OUT_W-1:0] q, k, v;
  } exp_t;
  exp_t sb[$];
  logic [IN_W-1:0] shadow [0:2][0:(1<<COL_W)-1];
  bit grant_log[$];

  task automatic sb_pop(input logic [1:0] k, output exp_t e, output bit ok);
    ok = 0;
    if (sb.size() == 0) begin
      check("sb_unexpected_output", {30'd0, k}, 2'd3);
    end else begin
      e = sb.pop_front();
      check("sb_kind", e.kind, k);
      ok = 1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit ok;
    #2;
    if (!rst) begin
      if (mem_valid && mem_ready) begin
        e.kind = mem_rd ? K_RD : K_WR;
        e.rdata = shadow[mem_sel][mem_col];
        if (!mem_rd) shadow[mem_sel][mem_col] = mem_wdata;
        sb.push_back(e);
        grant_log.push_back(1'b0);
      end
      if (tok_valid && tok_ready) begin
        e.kind = K_TOK;
        e.q = pat(0) ^ tok_data[OUT_W-1:0];
        e.k = pat(1) ^ tok_data[OUT_W-1:0];
        e.v = pat(2) ^ tok_data[OUT_W-1:0];
        if (dp_en) sb.push_back(e);
        grant_log.push_back(1'b1);
      end
      if (mem_wdone) sb_pop(K_WR, e, ok);
      if (mem_rvalid) begin
        sb_pop(K_RD, e, ok);
        if (ok) check("mem_rdata", mem_rdata, e.rdata);
      end
      if (out_valid && out_ready) begin
        sb_pop(K_TOK, e, ok);
        if (ok) begin
          check("out_q", out_q, e.q);
          check("out_k", out_k, e.k);
          check("out_v", out_v, e.v);
        end
      end
    end
  end

  task automatic do_mem(input bit rd, input logic [2:0] sel, input logic [COL_W-1:0] col,
                        input logic [IN_W-1:0] d);
    @(negedge clk);
    mem_valid = 1; mem_rd = rd; mem_sel = sel; mem_col = col; mem_wdata = d;
    for (int i = 0; i < 3000; i++) begin
      #1;
      if (mem_ready) begin
        @(negedge clk); mem_valid = 0;
        return;
      end
      @(negedge clk);
    end
    check("mem_accept_timeout", 0, 1);
    mem_valid = 0;
  endtask

  task automatic do_tok(input logic [IN_W-1:0] d);
    @(negedge clk);
    tok_valid = 1; tok_data = d;
    for (int i = 0; i < 3000; i++) begin
      #1;
      if (tok_ready) begin
        @(negedge clk); tok_valid = 0;
        return;
      end
      @(negedge clk);
    end
    check("tok_accept_timeout", 0, 1);
    tok_valid = 0;
  endtask

  task automatic wait_quiet(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #3;
      if (sb.size() == 0 && !busy) return;
    end
    check(tag, sb.size(), 0);
  endtask

  task automatic chk_reset_vals(input string p);
    check({p, "_busy"}, busy, 0);
    check({p, "_err"}, err, 0);
    check({p, "_mem_ready"}, mem_ready, 0);
    check({p, "_tok_ready"}, tok_ready, 0);
    check({p, "_out_valid"}, out_valid, 0);
    check({p, "_rvalid_wdone"}, {mem_rvalid, mem_wdone}, 0);
    check({p, "_dp_ctl"}, {dp_cs, dp_web, dp_cimeb}, 3'b011);
    check({p, "_dp_sel_col"}, {dp_weight_sel, dp_col_sel}, 0);
    check({p, "_dp_data_in"}, dp_data_in, 0);
    check({p, "_out_qkv"}, {out_q, out_k, out_v} == 0, 1);
    check({p, "_mem_rdata"}, mem_rdata, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IN_W-1:0] tv;
    logic [IN_W-1:0] a5 = {(IN_W/8){8'hA5}};

    repeat (3) @(negedge clk);
    #1 chk_reset_vals("rst");
    rst = 0;

    // Write then read back the same column.
    do_mem(0, 3'b001, 7'd5, a5);
    wait_quiet("write_drain");
    do_mem(1, 3'b001, 7'd5, '0);
    wait_quiet("read_drain");

    // Token compute with output backpressure and a blocked memory request.
    sel_log.delete();
    out_ready = 0;
    tv = rnd_vec();
    do_tok(tv);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (out_valid) break;
    end
    check("out_valid_seen", out_valid, 1);
    mem_valid = 1; mem_rd = 0; mem_sel = 3'b000; mem_col = 7'd2; mem_wdata = rnd_vec();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_q", out_q, pat(0) ^ tv[OUT_W-1:0]);
      check("bp_mem_ready", mem_ready, 0);
    end
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (mem_ready) break;
    end
    check("bp_mem_granted", mem_ready, 1);
    @(negedge clk); mem_valid = 0;
    wait_quiet("tok_drain");
    check("sel_log_len", sel_log.size(), 3);
    for (int i = 0; i < 3 && i < sel_log.size(); i++) check("sel_seq", sel_log[i], i);

    // Contention from reset: grants must alternate starting with memory.
    @(negedge clk); rst = 1;
    mem_valid = 1; mem_rd = 0; mem_sel = 3'b010; mem_col = 7'd1; mem_wdata = rnd_vec();
    tok_valid = 1; tok_data = rnd_vec();
    repeat (2) @(negedge clk);
    rst = 0;
    grant_log.delete();
    for (int i = 0; i < 2000 && grant_log.size() < 10; i++) begin
      @(negedge clk); #3;
    end
    @(negedge clk); mem_valid = 0; tok_valid = 0;
    wait_quiet("rr_drain");
    check("rr_count", grant_log.size() >= 10, 1);
    for (int i = 0; i < 10 && i < grant_log.size(); i++) check("rr_order", grant_log[i], i % 2);

    // Timeout: datapath never completes the first pass.
    dp_en = 0;
    do_tok(rnd_vec());
    repeat (TMO) @(posedge clk);
    #1;
    check("tmo_err_early", err, 0);
    check("tmo_busy_early", busy, 1);
    @(posedge clk); #1;
    check("tmo_err", err, 1);
    check("tmo_idle", busy, 0);
    check("tmo_out_valid", out_valid, 0);
    dp_en = 1;
    do_mem(0, 3'b000, 7'd3, rnd_vec());
    wait_quiet("post_tmo_drain");
    check("err_sticky", err, 1);

    // Reset during pass 1, then a clean token.
    tv = rnd_vec();
    do_tok(tv);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (dp_cs && dp_weight_sel == 3'd1) break;
    end
    check("pass1_reached", dp_weight_sel, 1);
    repeat (2) @(negedge clk);
    rst = 1;
    sb.delete();
    @(posedge clk); #1;
    chk_reset_vals("midop");
    @(negedge clk); rst = 0;
    tv = rnd_vec();
    do_tok(tv);
    wait_quiet("post_rst_drain");

    check("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
